// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings used by the immediate generator: opcodes,
// funct3 codes that select shift/CSR-immediate forms, and immediate type codes.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_CSRRWI  = 3'b101;
    localparam logic [2:0] F3_CSRRSI  = 3'b110;
    localparam logic [2:0] F3_CSRRCI  = 3'b111;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_ZIMM  = 3'd7
    } imm_type_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: classifies the instruction, builds the
// extended immediate and the pc-relative target for B/J/AUIPC.
module imm_decode
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_type,
    output logic [XLEN-1:0] target,
    output logic            illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic signed [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    imm_type_e  type_sel;
    logic [XLEN-1:0] imm_raw;
    logic       bad;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign i_imm  = {{20{instr[31]}}, instr[31:20]};
    assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign b_imm  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign u_imm  = {instr[31:12], 12'b0};
    assign j_imm  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        type_sel = IMM_NONE;
        imm_raw  = '0;
        bad      = 1'b0;
        unique case (opcode)
            OPC_LOAD, OPC_JALR: begin
                type_sel = IMM_I;
                imm_raw  = XLEN'(i_imm);
            end
            OPC_OP_IMM: begin
                if (funct3 == F3_SLL || funct3 == F3_SRL_SRA) begin
                    // RV32 shift with shamt[5] set has no legal meaning
                    if (XLEN == 32 && instr[25]) begin
                        bad = 1'b1;
                    end else begin
                        type_sel = IMM_SHAMT;
                        imm_raw  = XLEN'(instr[20 +: SHAMT_W]);
                    end
                end else begin
                    type_sel = IMM_I;
                    imm_raw  = XLEN'(i_imm);
                end
            end
            OPC_OP_IMM_32: begin
                if (XLEN != 64) begin
                    bad = 1'b1;
                end else if (funct3 == F3_SLL || funct3 == F3_SRL_SRA) begin
                    type_sel = IMM_SHAMT;
                    imm_raw  = XLEN'(instr[24:20]);
                end else begin
                    type_sel = IMM_I;
                    imm_raw  = XLEN'(i_imm);
                end
            end
            OPC_STORE: begin
                type_sel = IMM_S;
                imm_raw  = XLEN'(s_imm);
            end
            OPC_BRANCH: begin
                type_sel = IMM_B;
                imm_raw  = XLEN'(b_imm);
            end
            OPC_LUI, OPC_AUIPC: begin
                type_sel = IMM_U;
                imm_raw  = XLEN'(u_imm);
            end
            OPC_JAL: begin
                type_sel = IMM_J;
                imm_raw  = XLEN'(j_imm);
            end
            OPC_SYSTEM: begin
                if (funct3 == F3_CSRRWI || funct3 == F3_CSRRSI || funct3 == F3_CSRRCI) begin
                    type_sel = IMM_ZIMM;
                    imm_raw  = XLEN'(instr[19:15]);
                end
            end
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        illegal  = bad;
        imm_type = bad ? IMM_NONE : type_sel;
        imm      = bad ? '0 : imm_raw;
        target   = '0;
        if (!bad && (type_sel == IMM_B || type_sel == IMM_J || opcode == OPC_AUIPC)) begin
            target = pc + imm_raw;
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-entry (output + skid) registered pipeline around imm_decode; sustains
// one beat per cycle with a registered in_ready.
module imm_gen_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    logic [XLEN-1:0] dec_imm, dec_target;
    logic [2:0]      dec_type;
    logic            dec_illegal;

    imm_decode #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_decode (
        .instr    (in_instr),
        .pc       (in_pc),
        .imm      (dec_imm),
        .imm_type (dec_type),
        .target   (dec_target),
        .illegal  (dec_illegal)
    );

    logic            in_ready_q, out_valid_q, skid_valid_q;
    logic [XLEN-1:0] out_imm_q, out_target_q, skid_imm_q, skid_target_q;
    logic [2:0]      out_type_q, skid_type_q;
    logic            out_illegal_q, skid_illegal_q;

    logic accept, out_free, out_load_skid, out_load_in, skid_load;
    logic out_valid_d, skid_valid_d;

    // out_free: the output register is empty or retiring this cycle
    always_comb begin
        accept        = in_valid & in_ready_q & ~flush;
        out_free      = ~out_valid_q | out_ready;
        out_load_skid = out_free & skid_valid_q;
        out_load_in   = out_free & ~skid_valid_q & accept;
        skid_load     = ~out_free & accept;
        out_valid_d   = out_free ? (skid_valid_q | accept) : 1'b1;
        skid_valid_d  = out_free ? 1'b0 : (skid_valid_q | accept);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            skid_valid_q   <= 1'b0;
            out_imm_q      <= '0;
            out_type_q     <= IMM_NONE;
            out_target_q   <= '0;
            out_illegal_q  <= 1'b0;
            skid_imm_q     <= '0;
            skid_type_q    <= IMM_NONE;
            skid_target_q  <= '0;
            skid_illegal_q <= 1'b0;
        end else if (flush) begin
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            in_ready_q   <= ~skid_valid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            if (out_load_skid) begin
                out_imm_q     <= skid_imm_q;
                out_type_q    <= skid_type_q;
                out_target_q  <= skid_target_q;
                out_illegal_q <= skid_illegal_q;
            end else if (out_load_in) begin
                out_imm_q     <= dec_imm;
                out_type_q    <= dec_type;
                out_target_q  <= dec_target;
                out_illegal_q <= dec_illegal;
            end
            if (skid_load) begin
                skid_imm_q     <= dec_imm;
                skid_type_q    <= dec_type;
                skid_target_q  <= dec_target;
                skid_illegal_q <= dec_illegal;
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_imm      = out_imm_q;
    assign out_imm_type = out_type_q;
    assign out_target   = out_target_q;
    assign out_illegal  = out_illegal_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: RV32 and RV64 instances share stimulus;
// decode vectors, back-to-back flow, stall/skid, flush and mid-run reset.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        r32, v32, ill32;
    logic [31:0] imm32, tgt32;
    logic [2:0]  typ32;
    logic        r64, v64, ill64;
    logic [63:0] imm64, tgt64;
    logic [2:0]  typ64;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r32),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(v32), .out_ready(out_ready), .out_imm(imm32),
        .out_imm_type(typ32), .out_target(tgt32), .out_illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r64),
        .in_instr(in_instr), .in_pc({32'h0, in_pc}), .flush(flush),
        .out_valid(v64), .out_ready(out_ready), .out_imm(imm64),
        .out_imm_type(typ64), .out_target(tgt64), .out_illegal(ill64)
    );

    function automatic logic [31:0] addi(input logic [11:0] k);
        return {k, 20'h00013};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        repeat (3) tick();
        n_cmp++; if (r32 !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready32: got %b want 0", r32); end
        n_cmp++; if (r64 !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready64: got %b want 0", r64); end
        n_cmp++; if (v32 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", v32); end
        n_cmp++; if ({imm32, typ32, tgt32, ill32} !== 68'h0) begin n_bad++;
            $display("FAIL reset_outputs: got imm %h type %0d tgt %h ill %b want all 0", imm32, typ32, tgt32, ill32); end
        rst = 1'b0;
        tick();
        n_cmp++; if (r32 !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", r32); end
        $display("reset: in_ready=%b out_valid=%b", r32, v32);
    endtask

    typedef struct {
        logic [31:0] instr, pc, imm32, tgt32;
        logic [2:0]  t32;
        logic        i32;
        logic [63:0] imm64, tgt64;
        logic [2:0]  t64;
        logic        i64;
    } vec_t;

    task automatic test_decode();
        vec_t v [16];
        v[0]  = '{32'hFFF00093, 32'h0,    32'hFFFFFFFF, 32'h0,        3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 3'd1, 1'b0};
        v[1]  = '{32'h0080006F, 32'h1000, 32'h8,        32'h1008,     3'd5, 1'b0, 64'h8, 64'h1008, 3'd5, 1'b0};
        v[2]  = '{32'hFE000EE3, 32'h100,  32'hFFFFFFFC, 32'hFC,       3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'hFC, 3'd3, 1'b0};
        v[3]  = '{32'hFE000EE3, 32'h0,    32'hFFFFFFFC, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
        v[4]  = '{32'h43F0D093, 32'h0,    32'h0,        32'h0,        3'd0, 1'b1, 64'h3F, 64'h0, 3'd6, 1'b0};
        v[5]  = '{32'hFE20AC23, 32'h40,   32'hFFFFFFF8, 32'h0,        3'd2, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 3'd2, 1'b0};
        v[6]  = '{32'h12345037, 32'h40,   32'h12345000, 32'h0,        3'd4, 1'b0, 64'h12345000, 64'h0, 3'd4, 1'b0};
        v[7]  = '{32'hFFFFF097, 32'h2000, 32'hFFFFF000, 32'h1000,     3'd4, 1'b0, 64'hFFFFFFFFFFFFF000, 64'h1000, 3'd4, 1'b0};
        v[8]  = '{32'h300FD073, 32'h0,    32'h1F,       32'h0,        3'd7, 1'b0, 64'h1F, 64'h0, 3'd7, 1'b0};
        v[9]  = '{32'h00000073, 32'h0,    32'h0,        32'h0,        3'd0, 1'b0, 64'h0, 64'h0, 3'd0, 1'b0};
        v[10] = '{32'h0000007F, 32'h80,   32'h0,        32'h0,        3'd0, 1'b1, 64'h0, 64'h0, 3'd0, 1'b1};
        v[11] = '{32'h0010009B, 32'h0,    32'h0,        32'h0,        3'd0, 1'b1, 64'h1, 64'h0, 3'd1, 1'b0};
        v[12] = '{32'h00509093, 32'h0,    32'h5,        32'h0,        3'd6, 1'b0, 64'h5, 64'h0, 3'd6, 1'b0};
        v[13] = '{32'h4050D093, 32'h0,    32'h5,        32'h0,        3'd6, 1'b0, 64'h5, 64'h0, 3'd6, 1'b0};
        v[14] = '{32'h4050D09B, 32'h0,    32'h0,        32'h0,        3'd0, 1'b1, 64'h5, 64'h0, 3'd6, 1'b0};
        v[15] = '{32'h00C080E7, 32'h300,  32'hC,        32'h0,        3'd1, 1'b0, 64'hC, 64'h0, 3'd1, 1'b0};
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_instr = v[k].instr; in_pc = v[k].pc; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            n_cmp++; if (v32 !== 1'b1 || v64 !== 1'b1) begin n_bad++;
                $display("FAIL dec%0d_valid: got %b/%b want 1/1", k, v32, v64); end
            n_cmp++; if ({imm32, typ32, tgt32, ill32} !== {v[k].imm32, v[k].t32, v[k].tgt32, v[k].i32}) begin n_bad++;
                $display("FAIL dec%0d_rv32: got imm %h type %0d tgt %h ill %b want imm %h type %0d tgt %h ill %b",
                         k, imm32, typ32, tgt32, ill32, v[k].imm32, v[k].t32, v[k].tgt32, v[k].i32); end
            n_cmp++; if ({imm64, typ64, tgt64, ill64} !== {v[k].imm64, v[k].t64, v[k].tgt64, v[k].i64}) begin n_bad++;
                $display("FAIL dec%0d_rv64: got imm %h type %0d tgt %h ill %b want imm %h type %0d tgt %h ill %b",
                         k, imm64, typ64, tgt64, ill64, v[k].imm64, v[k].t64, v[k].tgt64, v[k].i64); end
            $display("decode %0d: instr %h pc %h -> imm32 %h type %0d tgt %h ill %b", k, v[k].instr, v[k].pc, imm32, typ32, tgt32, ill32);
        end
        tick();
        n_cmp++; if (v32 !== 1'b0) begin n_bad++; $display("FAIL dec_drain: got %b want 0", v32); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_instr = addi(12'(16 + k));
            tick();
            n_cmp++; if (v32 !== 1'b1 || imm32 !== 32'(16 + k) || r32 !== 1'b1) begin n_bad++;
                $display("FAIL b2b%0d: got valid %b imm %h ready %b want 1 %h 1", k, v32, imm32, r32, 32'(16 + k)); end
            $display("b2b %0d: imm %h", k, imm32);
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (v32 !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b want 0", v32); end
    endtask

    task automatic test_stall();
        logic [31:0] expq[$];
        logic [31:0] want;
        int idx = 0, got = 0, cyc = 0;
        logic acc, ret;
        logic [31:0] ret_imm;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = addi(12'(101));
        for (int c = 0; c < 3; c++) begin
            acc = r32;
            tick();
            if (acc) begin expq.push_back(32'(101 + idx)); idx++; in_instr = addi(12'(101 + idx)); end
            if (c >= 1) begin
                n_cmp++; if (r32 !== 1'b0) begin n_bad++; $display("FAIL stall_ready_c%0d: got %b want 0", c, r32); end
            end
        end
        n_cmp++; if (idx !== 2) begin n_bad++; $display("FAIL stall_accepted: got %0d want 2", idx); end
        n_cmp++; if (v32 !== 1'b1 || imm32 !== 32'd101) begin n_bad++;
            $display("FAIL stall_hold: got valid %b imm %h want 1 00000065", v32, imm32); end
        out_ready = 1'b1;
        while (got < 3 && cyc < 20) begin
            acc = in_valid && r32;
            ret = v32 && out_ready;
            ret_imm = imm32;
            tick();
            cyc++;
            if (ret) begin
                want = (expq.size() > 0) ? expq.pop_front() : 32'hDEAD;
                n_cmp++; if (ret_imm !== want) begin n_bad++; $display("FAIL stall_order%0d: got %h want %h", got, ret_imm, want); end
                $display("stall retire %0d: imm %h", got, ret_imm);
                got++;
            end
            if (acc) begin
                expq.push_back(32'(101 + idx)); idx++;
                if (idx == 3) in_valid = 1'b0; else in_instr = addi(12'(101 + idx));
            end
        end
        n_cmp++; if (got !== 3) begin n_bad++; $display("FAIL stall_timeout: got %0d beats want 3", got); end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = addi(12'(201)); tick();
        in_instr = addi(12'(202)); tick();
        n_cmp++; if (r32 !== 1'b0 || v32 !== 1'b1) begin n_bad++; $display("FAIL flush_full: got ready %b valid %b want 0 1", r32, v32); end
        flush = 1'b1; in_instr = addi(12'(203)); tick();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (v32 !== 1'b0 || r32 !== 1'b1) begin n_bad++; $display("FAIL flush_clear: got valid %b ready %b want 0 1", v32, r32); end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++; if (v32 !== 1'b0) begin n_bad++; $display("FAIL flush_ghost%0d: got valid %b imm %h want 0", c, v32, imm32); end
        end
        in_valid = 1'b1; in_instr = addi(12'(204)); tick(); in_valid = 1'b0;
        n_cmp++; if (v32 !== 1'b1 || imm32 !== 32'd204) begin n_bad++; $display("FAIL flush_after: got valid %b imm %h want 1 000000cc", v32, imm32); end
        $display("flush: post-flush beat imm %h", imm32);
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = addi(12'(301)); tick();
        in_instr = addi(12'(302)); tick();
        rst = 1'b1; flush = 1'b1; in_instr = addi(12'(303)); tick();
        n_cmp++; if (r32 !== 1'b0 || v32 !== 1'b0 || imm32 !== 32'h0) begin n_bad++;
            $display("FAIL rstmid_clear: got ready %b valid %b imm %h want 0 0 0", r32, v32, imm32); end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
        n_cmp++; if (r32 !== 1'b1 || v32 !== 1'b0) begin n_bad++; $display("FAIL rstmid_release: got ready %b valid %b want 1 0", r32, v32); end
        tick();
        n_cmp++; if (v32 !== 1'b0) begin n_bad++; $display("FAIL rstmid_ghost: got valid %b want 0", v32); end
        $display("reset_mid: ready %b valid %b", r32, v32);
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
